// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter in front of a shared 16x8 single-port memory; 3-cycle IDLE/ACCESS/DONE handshake.
// Define ROUND_ROBIN_EN for alternating tie-break; otherwise requester 0 has fixed priority.
module data_mem_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       we0,
    input  logic [3:0] addr0,
    input  logic [7:0] wdata0,
    output logic       gnt0,
    output logic       done0,
    output logic [7:0] rdata0,
    input  logic       req1,
    input  logic       we1,
    input  logic [3:0] addr1,
    input  logic [7:0] wdata1,
    output logic       gnt1,
    output logic       done1,
    output logic [7:0] rdata1,
    output logic       busy
);
    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    state_e        state_q;
    logic          win_q;
    logic          win_d;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          gnt0_q, gnt1_q, done0_q, done1_q, busy_q;
    logic [DW-1:0] rdata0_q, rdata1_q;
    logic [DW-1:0] mem_q [DEPTH];

`ifdef ROUND_ROBIN_EN
    logic last_q;

    // On a tie, requester 1 wins only if requester 0 was granted last.
    always_comb begin
        win_d = req1 & (~req0 | ~last_q);
    end
`else
    always_comb begin
        win_d = req1 & ~req0;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            win_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            busy_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifdef ROUND_ROBIN_EN
            last_q   <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0 | req1) begin
                        state_q <= ACCESS;
                        win_q   <= win_d;
                        we_q    <= win_d ? we1 : we0;
                        addr_q  <= win_d ? addr1 : addr0;
                        wdata_q <= win_d ? wdata1 : wdata0;
                        gnt0_q  <= ~win_d;
                        gnt1_q  <= win_d;
                        busy_q  <= 1'b1;
`ifdef ROUND_ROBIN_EN
                        last_q  <= win_d;
`endif
                    end
                end
                ACCESS: begin
                    state_q <= DONE;
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    done0_q <= ~win_q;
                    done1_q <= win_q;
                    if (!we_q) begin
                        if (win_q) rdata1_q <= mem_q[addr_q];
                        else       rdata0_q <= mem_q[addr_q];
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Storage is never reset; a write caught by reset is dropped.
    always_ff @(posedge clk) begin
        if (state_q == ACCESS && we_q && !rst) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign gnt0   = gnt0_q;
    assign gnt1   = gnt1_q;
    assign done0  = done0_q;
    assign done1  = done1_q;
    assign busy   = busy_q;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter; tie-break expectations follow ROUND_ROBIN_EN.
module tb_data_mem_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       req0, we0, req1, we1;
    logic [3:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, done0, gnt1, done1, busy;
    logic [7:0] rdata0, rdata1;
    int         total = 0;
    int         bad = 0;

    data_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .done0(done0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .done1(done1), .rdata1(rdata1),
        .busy(busy)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] C_IDLE  = 5'b00000;
    localparam logic [4:0] C_GNT0  = 5'b01001;
    localparam logic [4:0] C_GNT1  = 5'b10001;
    localparam logic [4:0] C_DONE0 = 5'b00011;
    localparam logic [4:0] C_DONE1 = 5'b00101;

    // {gnt1, gnt0, done1, done0, busy}
    function automatic logic [4:0] ctl();
        return {gnt1, gnt0, done1, done0, busy};
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One full transaction; inputs are scrambled right after the grant edge.
    task automatic txn(input bit r, input bit we, input logic [3:0] a,
                       input logic [7:0] d, input logic [3:0] alt_a);
        if (r) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        else   begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
        @(posedge clk); #1;
        if (r) begin req1 = 1'b0; we1 = ~we; addr1 = alt_a; wdata1 = ~d; end
        else   begin req0 = 1'b0; we0 = ~we; addr0 = alt_a; wdata0 = ~d; end
        @(negedge clk); chk("txn_gnt", 16'(ctl()), 16'(r ? C_GNT1 : C_GNT0));
        @(posedge clk); @(negedge clk); chk("txn_done", 16'(ctl()), 16'(r ? C_DONE1 : C_DONE0));
        @(posedge clk); @(negedge clk); chk("txn_idle", 16'(ctl()), 16'(C_IDLE));
    endtask

    initial begin
        logic [3:0] tie_win;
`ifdef ROUND_ROBIN_EN
        tie_win = 4'b1010;
`else
        tie_win = 4'b0000;
`endif
        rst = 1'b1;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        #2;
        chk("rst_ctl", 16'(ctl()), 16'(C_IDLE));
        chk("rst_rdata", {rdata1, rdata0}, 16'h0000);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);

        // Writes leave read ports alone; read-after-write returns new data.
        txn(0, 1, 4'd5, 8'hA7, 4'hE);
        chk("wr_rdata", {rdata1, rdata0}, 16'h0000);
        txn(1, 1, 4'd7, 8'h5A, 4'h1);
        txn(1, 0, 4'd7, 8'h00, 4'h2);
        chk("raw_rdata1", {rdata1, rdata0}, 16'h5A00);
        txn(0, 0, 4'd5, 8'h00, 4'h7);
        chk("rd_rdata0", {rdata1, rdata0}, 16'h5AA7);

        // Address and request change during ACCESS must not redirect the write.
        txn(1, 1, 4'd9, 8'h99, 4'h0);
        txn(1, 1, 4'd3, 8'h3C, 4'd9);
        txn(0, 0, 4'd9, 8'h00, 4'h3);
        chk("mid_mem9", {rdata1, rdata0}, 16'h5A99);
        txn(1, 0, 4'd3, 8'h00, 4'h9);
        chk("mid_mem3", {rdata1, rdata0}, 16'h3C99);

        // Request 1 arrives while requester 0 is in ACCESS.
        req0 = 1; we0 = 0; addr0 = 4'd5;
        @(posedge clk); #1;
        req0 = 0; req1 = 1; we1 = 0; addr1 = 4'd9;
        @(negedge clk); chk("q_gnt0", 16'(ctl()), 16'(C_GNT0));
        @(posedge clk); @(negedge clk); chk("q_done0", 16'(ctl()), 16'(C_DONE0));
        @(posedge clk); @(negedge clk); chk("q_idle", 16'(ctl()), 16'(C_IDLE));
        @(posedge clk); #1 req1 = 0;
        @(negedge clk); chk("q_gnt1", 16'(ctl()), 16'(C_GNT1));
        @(posedge clk); @(negedge clk); chk("q_done1", 16'(ctl()), 16'(C_DONE1));
        @(posedge clk); @(negedge clk); chk("q_rdata", {rdata1, rdata0}, 16'h99A7);

        // Reset in ACCESS drops the pending write.
        txn(0, 1, 4'd2, 8'h11, 4'h4);
        req0 = 1; we0 = 1; addr0 = 4'd2; wdata0 = 8'hFF;
        @(posedge clk); #1 req0 = 0;
        #1 chk("r_access", 16'(ctl()), 16'(C_GNT0));
        #1 rst = 1'b1;
        #1 chk("r_ctl", 16'(ctl()), 16'(C_IDLE));
        chk("r_rdata", {rdata1, rdata0}, 16'h0000);
        @(posedge clk); @(negedge clk); rst = 1'b0;

        // Tie held for four transactions, arbitrated from the first post-reset edge.
        req0 = 1; we0 = 0; addr0 = 4'd5;
        req1 = 1; we1 = 0; addr1 = 4'd7;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); @(negedge clk);
            chk("tie_gnt", 16'(ctl()), 16'(tie_win[k] ? C_GNT1 : C_GNT0));
            @(posedge clk); @(negedge clk);
            chk("tie_done", 16'(ctl()), 16'(tie_win[k] ? C_DONE1 : C_DONE0));
            @(posedge clk);
        end
        #1 req0 = 0;
        @(posedge clk); #1 req1 = 0;
        @(negedge clk); chk("solo_gnt1", 16'(ctl()), 16'(C_GNT1));
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("tie_rdata", {rdata1, rdata0}, 16'h5AA7);

        txn(0, 0, 4'd2, 8'h00, 4'h6);
        chk("r_mem2", 16'(rdata0), 16'h0011);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 The block SHALL run on one clock, `clk`, and one reset, `rst`; reset is asynchronous and active-high.
REQ-002 Port list, in this order (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst  in  1  async active-high reset
- req0  in  1  requester 0 (core load/store port) access request
- we0  in  1  requester 0: 1 = write, 0 = read
- addr0  in  4  requester 0 word address
- wdata0  in  8  requester 0 write data
- gnt0  out  1  requester 0 granted
- done0  out  1  requester 0 access complete (1-cycle pulse)
- rdata0  out  8  requester 0 read data
- req1, we1, addr1, wdata1, gnt1, done1, rdata1: same as requester 0, for requester 1 (loader/debug port)
- busy  out  1  high whenever the FSM is not in IDLE

Function
REQ-003 The block SHALL contain one shared 16 x 8-bit single-port storage array, accessed only through the arbiter.
REQ-004 The FSM SHALL have three states:
- IDLE
- ACCESS
- DONE
REQ-005 IDLE SHALL behave as follows:
- If any req is high at a rising edge, go to ACCESS.
- On that edge, latch the winner's we, addr and wdata and set the winner's gnt.
- If no req is high, stay in IDLE.
REQ-006 ACCESS SHALL last exactly one cycle:
- Hold gnt of the winner high.
- At the ending edge, perform the write (mem[addr] <= wdata) or the read (rdata_x <= mem[addr]).
- Clear gnt, set done of the winner, go to DONE.
REQ-007 DONE SHALL last exactly one cycle, holding done of the winner high, then return to IDLE with done cleared.
REQ-008 Latency: req sampled at edge N gives gnt high in cycle N+1 and done high in cycle N+2; the next arbitration is at the edge starting cycle N+4. Minimum spacing is 3 cycles per transaction.
REQ-009 Once granted, a transaction SHALL complete even if its req drops or its addr/we/wdata change; latched values are used.
REQ-010 A req still high at the IDLE sampling edge after DONE SHALL be treated as a new transaction. Requesters drop req in the cycle they see done.
REQ-011 rdata_x SHALL change only on a read completion for requester x, and hold its value otherwise, including across the other requester's transactions.
REQ-012 A write SHALL leave both rdata outputs unchanged.
REQ-013 At most one gnt and at most one done SHALL be high in any cycle; gnt and done of the same requester are never high together.
REQ-014 A request arriving while busy is high SHALL wait, never be dropped, and be arbitrated at the next IDLE edge.
REQ-015 A read of an address written in the immediately preceding transaction SHALL return the new data.
REQ-016 busy SHALL be high in ACCESS and in DONE.

Reset
REQ-017 On rst assertion, without waiting for a clock edge, the block SHALL set:
- state = IDLE
- gnt0, gnt1, done0, done1, busy = 0
- rdata0, rdata1 = 8'h00
- last-grant register = 1
REQ-018 Reset SHALL NOT clear the storage array.
REQ-019 If rst is asserted during ACCESS before the ending edge, the pending write SHALL be discarded.
REQ-020 The first arbitration SHALL occur at the first rising edge after rst deasserts.

Configuration
REQ-021 With `ROUND_ROBIN_EN` defined, simultaneous requests SHALL go to the requester not granted last. The last-grant register updates on each grant and resets to 1, so requester 0 wins the first tie.
REQ-022 Without `ROUND_ROBIN_EN`, requester 0 SHALL always win simultaneous requests. The last-grant register is not implemented.
REQ-023 With only one requester active, both configurations SHALL behave identically.

Verification
REQ-024 Write then read on requester 0: req0 at edge N with we0=1, addr0=5, wdata0=8'hA7 -> gnt0 high in N+1, done0 in N+2. A later read of addr 5 -> rdata0=8'hA7; rdata1 unchanged.
REQ-025 Simultaneous requests, ROUND_ROBIN_EN defined: req0=req1=1 held for four transactions -> grants go 0,1,0,1 with done pulses 3 cycles apart.
REQ-026 Same stimulus, ROUND_ROBIN_EN undefined -> four consecutive grants to requester 0; requester 1 is never granted until req0 drops.
REQ-027 Mid-transaction change: req1 write addr 3 = 8'h3C, with addr1 changed to 9 and req1 dropped during ACCESS -> mem[3]=8'h3C and mem[9] unchanged.
REQ-028 Reset mid-ACCESS: a requester 0 write of 8'hFF to addr 2 (mem[2] previously 8'h11) with rst pulsed in ACCESS -> all outputs 0 at once, and a later read returns mem[2]=8'h11.
REQ-029 Queued request: req1 rises while requester 0 is in ACCESS -> gnt1 no earlier than the cycle after done0 falls, busy continuously high except for one IDLE cycle.
